// File: rtl/axi_4_slave_controller.sv
// AXI4 slave handshake controller: one read or write burst in flight, beat sequencing, memory strobes.
// Optional write-length checking is enabled by defining AXI_SLAVE_LEN_CHECK_EN.
module axi_4_slave_controller #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_arvalid,
    input  logic [LEN_W-1:0] m_arlen,
    output logic             s_arready,
    input  logic             m_rready,
    output logic             s_rvalid,
    output logic             s_rlast,
    input  logic             m_awvalid,
    input  logic [LEN_W-1:0] m_awlen,
    output logic             s_awready,
    input  logic             m_wvalid,
    input  logic             m_wlast,
    output logic             s_wready,
    input  logic             m_bready,
    output logic             s_bvalid,
    output logic [1:0]       s_bresp,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [LEN_W-1:0] mem_beat
);

    localparam logic [LEN_W-1:0] BEAT_MAX = {LEN_W{1'b1}};

    typedef enum logic [1:0] {
        SLAVE_IDLE,
        READ_DATA,
        WRITE_DATA,
        WRITE_RESP
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] len;
    logic             error;

    // Handshake outputs decode purely from registered state, so no valid->ready path exists.
    assign s_arready = (state == SLAVE_IDLE);
    assign s_awready = (state == SLAVE_IDLE);
    assign s_wready  = (state == WRITE_DATA);
    assign s_rvalid  = (state == READ_DATA);
    assign s_rlast   = (state == READ_DATA) && (beat == len);
    assign s_bvalid  = (state == WRITE_RESP);
    assign s_bresp   = (s_bvalid && error) ? 2'b10 : 2'b00;

    // Memory strobes fire in the handshake cycle so read data lines up with the next s_rvalid beat.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_beat  = beat;
        unique case (state)
            SLAVE_IDLE: begin
                if (m_arvalid) begin
                    mem_rd_en = 1'b1;
                    mem_beat  = '0;
                end
            end
            READ_DATA: begin
                if (m_rready && !s_rlast) begin
                    mem_rd_en = 1'b1;
                    mem_beat  = LEN_W'(beat + 1'b1);
                end
            end
            WRITE_DATA: begin
                if (m_wvalid) begin
                    mem_wr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SLAVE_IDLE;
            beat  <= '0;
            len   <= '0;
            error <= 1'b0;
        end else begin
            unique case (state)
                SLAVE_IDLE: begin
                    beat <= '0;
                    if (m_arvalid) begin
                        len   <= m_arlen;
                        state <= READ_DATA;
                    end else if (m_awvalid) begin
                        len   <= m_awlen;
                        error <= 1'b0;
                        state <= WRITE_DATA;
                    end
                end
                READ_DATA: begin
                    if (m_rready) begin
                        if (s_rlast) begin
                            beat  <= '0;
                            state <= SLAVE_IDLE;
                        end else begin
                            beat <= LEN_W'(beat + 1'b1);
                        end
                    end
                end
                WRITE_DATA: begin
                    if (m_wvalid) begin
                        if (beat != BEAT_MAX) begin
                            beat <= LEN_W'(beat + 1'b1);
                        end
`ifdef AXI_SLAVE_LEN_CHECK_EN
                        if ((beat > len) || (m_wlast && (beat != len))) begin
                            error <= 1'b1;
                        end
`endif
                        if (m_wlast) begin
                            state <= WRITE_RESP;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (m_bready) begin
                        beat  <= '0;
                        state <= SLAVE_IDLE;
                    end
                end
                default: state <= SLAVE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_4_slave_controller.sv
// Directed testbench for axi_4_slave_controller with hand-computed expectations.
module tb_axi_4_slave_controller;

    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             reset;
    logic             m_arvalid;
    logic [LEN_W-1:0] m_arlen;
    logic             s_arready;
    logic             m_rready;
    logic             s_rvalid;
    logic             s_rlast;
    logic             m_awvalid;
    logic [LEN_W-1:0] m_awlen;
    logic             s_awready;
    logic             m_wvalid;
    logic             m_wlast;
    logic             s_wready;
    logic             m_bready;
    logic             s_bvalid;
    logic [1:0]       s_bresp;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [LEN_W-1:0] mem_beat;

    int errors = 0;
    int checks = 0;

    axi_4_slave_controller #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_arvalid (m_arvalid),
        .m_arlen   (m_arlen),
        .s_arready (s_arready),
        .m_rready  (m_rready),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .m_awvalid (m_awvalid),
        .m_awlen   (m_awlen),
        .s_awready (s_awready),
        .m_wvalid  (m_wvalid),
        .m_wlast   (m_wlast),
        .s_wready  (s_wready),
        .m_bready  (m_bready),
        .s_bvalid  (s_bvalid),
        .s_bresp   (s_bresp),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_beat  (mem_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes before sampling.
    task automatic settle();
        #1;
    endtask

    logic [1:0] short_resp;

    initial begin
        reset = 1'b0; m_arvalid = 0; m_arlen = '0; m_rready = 0;
        m_awvalid = 0; m_awlen = '0; m_wvalid = 0; m_wlast = 0; m_bready = 0;
`ifdef AXI_SLAVE_LEN_CHECK_EN
        short_resp = 2'b10;
`else
        short_resp = 2'b00;
`endif

        // Reset state
        tick(); settle();
        chk("rst_arready", 32'(s_arready), 32'd1);
        chk("rst_awready", 32'(s_awready), 32'd1);
        chk("rst_wready",  32'(s_wready),  32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_rlast",   32'(s_rlast),   32'd0);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_bresp",   32'(s_bresp),   32'd0);
        chk("rst_rd_en",   32'(mem_rd_en), 32'd0);
        chk("rst_wr_en",   32'(mem_wr_en), 32'd0);
        reset = 1'b1;
        tick();

        // Read arlen=3 with m_rready held high
        m_arvalid = 1; m_arlen = 8'd3; m_rready = 1; settle();
        chk("r4_ar_ready", 32'(s_arready), 32'd1);
        chk("r4_ar_rd_en", 32'(mem_rd_en), 32'd1);
        chk("r4_ar_beat",  32'(mem_beat),  32'd0);
        chk("r4_ar_rvalid", 32'(s_rvalid), 32'd0);
        tick(); m_arvalid = 0; settle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("r4_rvalid_%0d", i), 32'(s_rvalid),  32'd1);
            chk($sformatf("r4_rlast_%0d", i),  32'(s_rlast),   32'(i == 3));
            chk($sformatf("r4_rd_en_%0d", i),  32'(mem_rd_en), 32'(i < 3));
            if (i < 3) chk($sformatf("r4_beat_%0d", i), 32'(mem_beat), 32'(i + 1));
            chk($sformatf("r4_arready_%0d", i), 32'(s_arready), 32'd0);
            tick();
        end
        m_rready = 0; settle();
        chk("r4_idle_rvalid",  32'(s_rvalid),  32'd0);
        chk("r4_idle_arready", 32'(s_arready), 32'd1);

        // Read arlen=1 with two stalled cycles on beat 0
        m_arvalid = 1; m_arlen = 8'd1; settle();
        chk("r2_ar_rd_en", 32'(mem_rd_en), 32'd1);
        tick(); m_arvalid = 0; settle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("r2_stall_rvalid_%0d", i), 32'(s_rvalid),  32'd1);
            chk($sformatf("r2_stall_rlast_%0d", i),  32'(s_rlast),   32'd0);
            chk($sformatf("r2_stall_rd_en_%0d", i),  32'(mem_rd_en), 32'd0);
            chk($sformatf("r2_stall_beat_%0d", i),   32'(mem_beat),  32'd0);
            tick(); settle();
        end
        m_rready = 1; settle();
        chk("r2_b0_rd_en", 32'(mem_rd_en), 32'd1);
        chk("r2_b0_beat",  32'(mem_beat),  32'd1);
        chk("r2_b0_rlast", 32'(s_rlast),   32'd0);
        tick(); settle();
        chk("r2_b1_rlast", 32'(s_rlast),   32'd1);
        chk("r2_b1_rd_en", 32'(mem_rd_en), 32'd0);
        tick(); m_rready = 0; settle();
        chk("r2_idle_rvalid", 32'(s_rvalid), 32'd0);

        // Write awlen=2, three beats, m_wlast on third
        m_awvalid = 1; m_awlen = 8'd2; settle();
        chk("w3_aw_ready", 32'(s_awready), 32'd1);
        chk("w3_aw_wr_en", 32'(mem_wr_en), 32'd0);
        tick(); m_awvalid = 0;
        for (int i = 0; i < 3; i++) begin
            m_wvalid = 1; m_wlast = (i == 2); settle();
            chk($sformatf("w3_wready_%0d", i), 32'(s_wready),  32'd1);
            chk($sformatf("w3_wr_en_%0d", i),  32'(mem_wr_en), 32'd1);
            chk($sformatf("w3_beat_%0d", i),   32'(mem_beat),  32'(i));
            chk($sformatf("w3_bvalid_%0d", i), 32'(s_bvalid),  32'd0);
            tick();
        end
        m_wvalid = 0; m_wlast = 0; settle();
        chk("w3_bvalid", 32'(s_bvalid), 32'd1);
        chk("w3_bresp",  32'(s_bresp),  32'd0);
        chk("w3_wready", 32'(s_wready), 32'd0);
        tick(); settle();
        chk("w3_bvalid_hold", 32'(s_bvalid), 32'd1);
        m_bready = 1; tick(); m_bready = 0; settle();
        chk("w3_idle_bvalid",  32'(s_bvalid),  32'd0);
        chk("w3_idle_awready", 32'(s_awready), 32'd1);

        // Simultaneous ar and aw: read first, then the write address
        m_arvalid = 1; m_arlen = 8'd0; m_awvalid = 1; m_awlen = 8'd0; m_rready = 1;
        tick(); m_arvalid = 0; settle();
        chk("rw_rvalid",  32'(s_rvalid),  32'd1);
        chk("rw_rlast",   32'(s_rlast),   32'd1);
        chk("rw_awready", 32'(s_awready), 32'd0);
        chk("rw_wready",  32'(s_wready),  32'd0);
        tick(); m_rready = 0; settle();
        chk("rw_idle_awready", 32'(s_awready), 32'd1);
        tick(); m_awvalid = 0; settle();
        chk("rw_w_wready", 32'(s_wready), 32'd1);
        m_wvalid = 1; m_wlast = 1; settle();
        chk("rw_w_wr_en", 32'(mem_wr_en), 32'd1);
        chk("rw_w_beat",  32'(mem_beat),  32'd0);
        tick(); m_wvalid = 0; m_wlast = 0; settle();
        chk("rw_bvalid", 32'(s_bvalid), 32'd1);
        chk("rw_bresp",  32'(s_bresp),  32'd0);
        m_bready = 1; tick(); m_bready = 0;

        // awlen=3 terminated early by m_wlast on beat 1
        m_awvalid = 1; m_awlen = 8'd3; tick(); m_awvalid = 0;
        m_wvalid = 1; m_wlast = 0; tick();
        m_wlast = 1; settle();
        chk("short_beat1", 32'(mem_beat), 32'd1);
        tick(); m_wvalid = 0; m_wlast = 0; settle();
        chk("short_bvalid", 32'(s_bvalid), 32'd1);
        chk("short_bresp",  32'(s_bresp),  32'(short_resp));
        m_bready = 1; tick(); m_bready = 0; settle();
        chk("short_idle_bresp", 32'(s_bresp), 32'd0);

        // Reset asserted during beat 2 of an arlen=5 read
        m_arvalid = 1; m_arlen = 8'd5; m_rready = 1; tick(); m_arvalid = 0;
        tick(); tick(); m_rready = 0; settle();
        chk("rr_pre_rvalid", 32'(s_rvalid), 32'd1);
        chk("rr_pre_beat",   32'(mem_beat), 32'd2);
        reset = 1'b0; settle();
        chk("rr_rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rr_rst_arready", 32'(s_arready), 32'd1);
        tick(); reset = 1'b1;
        m_arvalid = 1; m_arlen = 8'd2; settle();
        chk("rr_new_rd_en", 32'(mem_rd_en), 32'd1);
        chk("rr_new_beat",  32'(mem_beat),  32'd0);
        tick(); m_arvalid = 0; settle();
        chk("rr_new_rvalid", 32'(s_rvalid), 32'd1);
        chk("rr_new_b0",     32'(mem_beat), 32'd0);
        chk("rr_new_rlast",  32'(s_rlast),  32'd0);
        m_rready = 1; tick(); tick(); settle();
        chk("rr_new_last", 32'(s_rlast), 32'd1);
        tick(); m_rready = 0; settle();
        chk("rr_new_idle", 32'(s_arready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
